// File: rtl/reg_file_writer.sv
// -----------------------------------------------------------------------------
// reg_file_writer
//
// Purpose:
//   Funnels three result producers (alu, mul, ld) onto a single register-file
//   write port. One request is accepted per cycle under round-robin priority.
//   Accepted writes appear on the write port one cycle later from registers.
//   Writes to register 0 complete their handshake but never raise the write
//   enable. An optional pending-register scoreboard tracks destinations that
//   the issue stage has claimed and that are still awaiting writeback.
//
// Configuration macro:
//   OPT_WRITER_SCOREBOARD_EN - when defined, the out_pending scoreboard is
//                              built. When undefined, out_pending is tied to 0
//                              and the claim inputs are ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_<p>_valid/sel/data      producer request (p = alu, mul, ld)
//   out_<p>_ready              combinational grant, at most one high
//   in_claim_en/sel            issue-stage claim of a destination register
//   out_write_en/sel/data      registered register-file write port
//   out_pending                per-register "awaiting writeback" flags
//   out_busy                   OR of all producer valids
// -----------------------------------------------------------------------------
module reg_file_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        in_alu_valid,
  input  logic [$clog2(NUM_REGS)-1:0] in_alu_sel,
  input  logic [DATA_WIDTH-1:0]       in_alu_data,
  output logic                        out_alu_ready,

  input  logic                        in_mul_valid,
  input  logic [$clog2(NUM_REGS)-1:0] in_mul_sel,
  input  logic [DATA_WIDTH-1:0]       in_mul_data,
  output logic                        out_mul_ready,

  input  logic                        in_ld_valid,
  input  logic [$clog2(NUM_REGS)-1:0] in_ld_sel,
  input  logic [DATA_WIDTH-1:0]       in_ld_data,
  output logic                        out_ld_ready,

  input  logic                        in_claim_en,
  input  logic [$clog2(NUM_REGS)-1:0] in_claim_sel,

  output logic                        out_write_en,
  output logic [$clog2(NUM_REGS)-1:0] out_write_sel,
  output logic [DATA_WIDTH-1:0]       out_write_data,
  output logic [NUM_REGS-1:0]         out_pending,
  output logic                        out_busy
);

  localparam int unsigned SelW = $clog2(NUM_REGS);

  // Source indices: 0 = alu, 1 = mul, 2 = ld.
  logic [2:0]            w_valid;
  logic [1:0]            w_cand [3];
  logic                  w_xfer;
  logic [1:0]            w_grant_idx;
  logic [2:0]            w_grant;
  logic [SelW-1:0]       w_sel;
  logic [DATA_WIDTH-1:0] w_data;
  logic [1:0]            w_rr_next;

  logic [1:0]            r_rr_ptr;
  logic                  r_write_en;
  logic [SelW-1:0]       r_write_sel;
  logic [DATA_WIDTH-1:0] r_write_data;

  // Requests are masked during reset so no grant or transfer can occur.
  assign w_valid = {in_ld_valid, in_mul_valid, in_alu_valid} & {3{rst_n}};

  // Search order starting at the priority pointer, wrapping mod 3.
  always_comb begin
    case (r_rr_ptr)
      2'd1: begin
        w_cand[0] = 2'd1;
        w_cand[1] = 2'd2;
        w_cand[2] = 2'd0;
      end
      2'd2: begin
        w_cand[0] = 2'd2;
        w_cand[1] = 2'd0;
        w_cand[2] = 2'd1;
      end
      default: begin
        w_cand[0] = 2'd0;
        w_cand[1] = 2'd1;
        w_cand[2] = 2'd2;
      end
    endcase
  end

  // First valid candidate in search order wins.
  always_comb begin
    w_xfer      = 1'b0;
    w_grant_idx = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!w_xfer && w_valid[w_cand[i]]) begin
        w_xfer      = 1'b1;
        w_grant_idx = w_cand[i];
      end
    end
  end

  always_comb begin
    w_grant = 3'b000;
    if (w_xfer) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign out_alu_ready = w_grant[0];
  assign out_mul_ready = w_grant[1];
  assign out_ld_ready  = w_grant[2];

  // Payload of the granted producer.
  always_comb begin
    case (w_grant_idx)
      2'd1: begin
        w_sel  = in_mul_sel;
        w_data = in_mul_data;
      end
      2'd2: begin
        w_sel  = in_ld_sel;
        w_data = in_ld_data;
      end
      default: begin
        w_sel  = in_alu_sel;
        w_data = in_alu_data;
      end
    endcase
  end

  assign w_rr_next = (w_grant_idx == 2'd2) ? 2'd0 : (w_grant_idx + 2'd1);

  // Arbitration pointer and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= 2'd0;
      r_write_en   <= 1'b0;
      r_write_sel  <= '0;
      r_write_data <= '0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr <= w_rr_next;
      end
      // Register 0 is hardwired: the handshake completes but nothing is written
      // and the last real write payload is kept on the port.
      if (w_xfer && (w_sel != '0)) begin
        r_write_en   <= 1'b1;
        r_write_sel  <= w_sel;
        r_write_data <= w_data;
      end else begin
        r_write_en   <= 1'b0;
      end
    end
  end

  assign out_write_en   = r_write_en;
  assign out_write_sel  = r_write_sel;
  assign out_write_data = r_write_data;
  assign out_busy       = in_alu_valid | in_mul_valid | in_ld_valid;

`ifdef OPT_WRITER_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_d;

  // Clear on writeback first, then set on claim so a same-cycle claim wins.
  always_comb begin
    w_pending_d = r_pending;
    if (w_xfer) begin
      w_pending_d[w_sel] = 1'b0;
    end
    if (in_claim_en) begin
      w_pending_d[in_claim_sel] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  assign out_pending = r_pending;
`else
  logic w_unused_claim;

  assign w_unused_claim = in_claim_en ^ (^in_claim_sel);
  assign out_pending    = '0;
`endif

endmodule

// File: tb/tb_reg_file_writer.sv
module tb_reg_file_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

`ifdef OPT_WRITER_SCOREBOARD_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          alu_v, mul_v, ld_v;
  logic [3:0]    alu_s, mul_s, ld_s;
  logic [DW-1:0] alu_d, mul_d, ld_d;
  logic          alu_r, mul_r, ld_r;
  logic          claim_en;
  logic [3:0]    claim_sel;
  logic          we;
  logic [3:0]    wsel;
  logic [DW-1:0] wdata;
  logic [NR-1:0] pending;
  logic          busy;

  int checks;
  int failures;

  reg_file_writer #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_alu_valid  (alu_v),
    .in_alu_sel    (alu_s),
    .in_alu_data   (alu_d),
    .out_alu_ready (alu_r),
    .in_mul_valid  (mul_v),
    .in_mul_sel    (mul_s),
    .in_mul_data   (mul_d),
    .out_mul_ready (mul_r),
    .in_ld_valid   (ld_v),
    .in_ld_sel     (ld_s),
    .in_ld_data    (ld_d),
    .out_ld_ready  (ld_r),
    .in_claim_en   (claim_en),
    .in_claim_sel  (claim_sel),
    .out_write_en  (we),
    .out_write_sel (wsel),
    .out_write_data(wdata),
    .out_pending   (pending),
    .out_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          av;
    logic [3:0]    as;
    logic [DW-1:0] ad;
    logic          mv;
    logic [3:0]    ms;
    logic [DW-1:0] md;
    logic          lv;
    logic [3:0]    ls;
    logic [DW-1:0] ld;
    logic [2:0]    rdy;   // {ld, mul, alu}
    logic          we;
    logic          chkd;  // compare write sel/data
    logic [3:0]    ws;
    logic [DW-1:0] wd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] as, input logic [DW-1:0] ad,
                       input logic mv, input logic [3:0] ms, input logic [DW-1:0] md,
                       input logic lv, input logic [3:0] ls, input logic [DW-1:0] ld);
    alu_v = av; alu_s = as; alu_d = ad;
    mul_v = mv; mul_s = ms; mul_d = md;
    ld_v  = lv; ld_s  = ls; ld_d  = ld;
  endtask

  task automatic claim(input logic en, input logic [3:0] sel);
    claim_en  = en;
    claim_sel = sel;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0,     3'b001, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,     0, 0, 0,     3'b000, 1, 1, 3, 32'hDEADBEEF};
    vecs[2]  = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 3, 32'h33, 3'b010, 0, 1, 3, 32'hDEADBEEF};
    vecs[3]  = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 3, 32'h33, 3'b100, 1, 1, 2, 32'h22};
    vecs[4]  = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 3, 32'h33, 3'b001, 1, 1, 3, 32'h33};
    vecs[5]  = '{1, 1, 32'h11,       1, 2, 32'h22, 1, 3, 32'h33, 3'b010, 1, 1, 1, 32'h11};
    vecs[6]  = '{1, 4, 32'h44,       0, 0, 0,     0, 0, 0,     3'b001, 1, 1, 2, 32'h22};
    vecs[7]  = '{0, 0, 0,            1, 6, 32'h66, 1, 0, 32'h55, 3'b010, 1, 1, 4, 32'h44};
    vecs[8]  = '{0, 0, 0,            0, 0, 0,     1, 0, 32'h55, 3'b100, 1, 1, 6, 32'h66};
    vecs[9]  = '{1, 7, 32'h77,       0, 0, 0,     1, 8, 32'h88, 3'b001, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0,            0, 0, 0,     1, 8, 32'h88, 3'b100, 1, 1, 7, 32'h77};
    vecs[11] = '{0, 0, 0,            0, 0, 0,     0, 0, 0,     3'b000, 1, 1, 8, 32'h88};
    vecs[12] = '{0, 0, 0,            0, 0, 0,     0, 0, 0,     3'b000, 0, 1, 8, 32'h88};

    // Reset state, with requests present to confirm no grant while in reset.
    rst_n = 1'b0;
    claim(0, 0);
    drive(1, 1, 32'h11, 1, 2, 32'h22, 1, 3, 32'h33);
    #3;
    chk("rst_ready", {ld_r, mul_r, alu_r}, 3'b000);
    chk("rst_we", we, 0);
    chk("rst_wsel", wsel, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #9 rst_n = 1'b1;

    // Table-driven arbitration / write-port vectors.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].av, vecs[i].as, vecs[i].ad, vecs[i].mv, vecs[i].ms, vecs[i].md,
            vecs[i].lv, vecs[i].ls, vecs[i].ld);
      #1;
      chk($sformatf("v%0d_ready", i), {ld_r, mul_r, alu_r}, vecs[i].rdy);
      chk($sformatf("v%0d_we", i), we, vecs[i].we);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].av | vecs[i].mv | vecs[i].lv);
      if (vecs[i].chkd) begin
        chk($sformatf("v%0d_wsel", i), wsel, vecs[i].ws);
        chk($sformatf("v%0d_wdata", i), wdata, vecs[i].wd);
      end
    end

    // Reset mid-operation: transfer, then reset in the write cycle.
    @(posedge clk);
    #1 drive(1, 9, 32'hA5A5_0009, 0, 0, 0, 0, 0, 0);
    #1 chk("mr_ready", {ld_r, mul_r, alu_r}, 3'b001);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("mr_we_before", we, 1);
    chk("mr_wsel_before", wsel, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_we_async", we, 0);
    chk("mr_wsel_async", wsel, 0);
    chk("mr_wdata_async", wdata, 0);
    chk("mr_pending_async", pending, 0);
    drive(1, 1, 32'h11, 1, 2, 32'h22, 1, 3, 32'h33);
    #1 chk("mr_ready_in_rst", {ld_r, mul_r, alu_r}, 3'b000);
    @(posedge clk);
    #2 chk("mr_we_held", we, 0);
    rst_n = 1'b1;
    #1;
    chk("mr_first_grant", {ld_r, mul_r, alu_r}, 3'b001);
    chk("mr_no_stale_we", we, 0);

    // Continuous contention after reset: alu, mul, ld, alu, ...
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #2;
      chk($sformatf("rr%0d_ready", i), {ld_r, mul_r, alu_r}, 3'b001 << (i % 3));
      chk($sformatf("rr%0d_we", i), we, 1);
      chk($sformatf("rr%0d_wsel", i), wsel, ((i - 1) % 3) + 1);
      chk($sformatf("rr%0d_wdata", i), wdata, 32'h11 * (((i - 1) % 3) + 1));
    end

    // Scoreboard sequence.
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    claim(1, 5);
    #1 chk("sb_before_claim", pending, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 5, 32'h5A, 0, 0, 0);
    claim(1, 5);
    #1 chk("sb_claim5", pending, SbEn ? 16'h0020 : 16'h0000);
    chk("sb_mul_ready", {ld_r, mul_r, alu_r}, 3'b010);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    claim(0, 0);
    #1 chk("sb_claim_wins", pending, SbEn ? 16'h0020 : 16'h0000);
    chk("sb_we5", we, 1);
    chk("sb_wdata5", wdata, 32'h5A);
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 5, 32'h5B, 0, 0, 0);
    #1 chk("sb_still_pending", pending, SbEn ? 16'h0020 : 16'h0000);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    claim(1, 0);
    #1 chk("sb_cleared", pending, 0);
    @(posedge clk);
    #1 claim(1, 7);
    #1 chk("sb_claim0_ignored", pending, 0);
    @(posedge clk);
    #1 claim(0, 0);
    #1 chk("sb_claim7", pending, SbEn ? 16'h0080 : 16'h0000);
    chk("sb_idle_we", we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_writer.md
REG_FILE_WRITER -- requirements
Module: reg_file_writer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, register data width; NUM_REGS, default 16, register count (select width 4).
REQ-002 Port list SHALL be, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 Producer ports, for each p in {alu, mul, ld} (source index 0, 1, 2):
- in_<p>_valid  in  1  write request.
- in_<p>_sel  in  4  destination register.
- in_<p>_data  in  DATA_WIDTH  result.
- out_<p>_ready  out  1  request accepted this cycle.
REQ-004 Scoreboard claim ports:
- in_claim_en  in  1  issue stage marks a destination pending.
- in_claim_sel  in  4  register being claimed.
REQ-005 Register-file write port and status outputs:
- out_write_en  out  1  register-file write enable.
- out_write_sel  out  4  register-file write select.
- out_write_data  out  DATA_WIDTH  register-file write data.
- out_pending  out  NUM_REGS  bit i set = register i awaits writeback.
- out_busy  out  1  any in_<p>_valid is high this cycle.

Function
REQ-006 The block SHALL drive the single register-file write port from the three producers, one accepted request per cycle.
REQ-007 A transfer on producer p SHALL occur in any cycle where in_<p>_valid and out_<p>_ready are both high.
REQ-008 out_<p>_ready SHALL be combinational and high only for the granted producer, with at most one ready high per cycle.
REQ-009 Arbitration SHALL be round-robin:
- A 2-bit priority pointer rr_ptr holds a value in 0..2.
- The search order is rr_ptr, rr_ptr+1, rr_ptr+2, each mod 3; the first valid producer in that order is granted.
REQ-010 After a transfer from source k, rr_ptr SHALL become (k+1) mod 3; with no transfer, rr_ptr SHALL hold.
REQ-011 Write latency SHALL be one cycle: a transfer in cycle N drives out_write_en, out_write_sel and out_write_data from registers in cycle N+1.
REQ-012 out_write_en SHALL be low in every cycle that follows a cycle with no transfer; out_write_sel and out_write_data SHALL hold their last values.
REQ-013 A transfer to register 0 SHALL complete its handshake and advance rr_ptr, but SHALL leave out_write_en low in cycle N+1.
REQ-014 The selected producer SHALL be able to change or drop valid in the cycle after its transfer without affecting the value already registered.
REQ-015 out_pending scoreboard behaviour:
- A claim (in_claim_en) sets bit in_claim_sel on the next edge.
- A transfer to register r clears bit r on the next edge.
- A claim and a transfer to the same register in the same cycle leave the bit set (new claim wins).
- A claim of register 0 is ignored, and out_pending[0] stays 0.
REQ-016 A transfer to a register whose pending bit is clear SHALL be accepted normally, with no error and no scoreboard change.
REQ-017 out_busy SHALL be the OR of the three in_<p>_valid inputs.

Reset
REQ-018 While rst_n is low, the following SHALL hold immediately, regardless of clk:
- out_write_en = 0, out_write_sel = 0, out_write_data = 0.
- out_pending = 0.
- rr_ptr = 0.
REQ-019 While rst_n is low, all out_<p>_ready SHALL be 0 and no transfer SHALL occur.
REQ-020 A transfer registered before a reset assertion SHALL be discarded: no write_en pulse occurs after reset releases.
REQ-021 The first arbitration after reset release SHALL start with priority to alu.

Configuration
REQ-022 Macro OPT_WRITER_SCOREBOARD_EN SHALL control the scoreboard:
- Defined: the out_pending scoreboard per REQ-015 is implemented.
- Undefined: out_pending is tied to 0, in_claim_en and in_claim_sel are ignored, and no scoreboard storage is synthesised.
- Arbitration and write-port behaviour are identical in both builds.

Verification
REQ-023 Single producer: alu valid, sel=3, data=0xDEADBEEF, all others idle -> out_alu_ready=1 in cycle N; in N+1, out_write_en=1, out_write_sel=3, out_write_data=0xDEADBEEF.
REQ-024 Contention: all three producers valid continuously after reset with sels 1/2/3 -> grants alu, mul, ld, alu, ...; one write_en pulse per cycle.
REQ-025 Register 0: ld valid, sel=0, data=0x55 -> out_ld_ready=1; out_write_en stays 0 in N+1; rr_ptr advances to alu.
REQ-026 Scoreboard (macro defined):
- Claim sel=5 -> out_pending=0x0020 next cycle.
- mul writes sel=5 while a simultaneous claim of sel=5 is made -> out_pending stays 0x0020.
- A later write to sel=5 with no claim -> out_pending=0x0000.
REQ-027 Reset mid-operation: rst_n driven low asynchronously in the cycle after a transfer -> out_write_en drops to 0 immediately, out_pending=0; after release, no stale write pulse and alu has priority.
REQ-028 Macro undefined: claim sel=7 -> out_pending remains 0x0000; the REQ-024 grant sequence is unchanged.
